mul_fu: RTL

Pipelined RV32M multiply functional unit sitting directly downstream of the multiply-class reservation station. It consumes the issued reservation-station entry together with its register-file operands and computes MUL/MULH/MULHSU/MULHU in a fixed-latency, non-stalling pipeline. Results are buffered in a result FIFO and presented to the CDB arbiter. The unit throttles the station with `fu_ready` so that the FIFO can never overflow.

---
 rtl/mul_fu_pkg.sv | 38 +++
 rtl/mul_fu_fifo.sv | 53 +++++
 rtl/mul_fu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mul_fu_pkg.sv
// Shared types for the RV32M multiply unit: station entry, CDB payload, funct3 codes
// and the product-to-result selection.
package mul_fu_pkg;

  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mul_funct3_t;

  typedef struct packed {
    logic              cdb_valid;
    logic [PREG_W-1:0] preg_index;
    logic [ROB_W-1:0]  rob_index;
    logic [31:0]       data;
  } cdb_t;

  typedef struct packed {
    logic              valid;
    logic [2:0]        funct3;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_index;
  } reservation_station_entry_t;

  // Unknown funct3 (divide codes) still writes back, with zero data.
  function automatic logic [31:0] mul_select(input logic [2:0] f3, input logic [63:0] prod);
    case (f3)
      MUL:                 return prod[31:0];
      MULH, MULHSU, MULHU: return prod[63:32];
      default:             return '0;
    endcase
  endfunction

endpackage

// File: rtl/mul_fu_fifo.sv
// Result FIFO between the multiply pipeline and the CDB arbiter.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module mul_result_fifo #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 43
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= f_inc(r_wr);
      if (i_pop)  r_rd <= f_inc(r_rd);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/mul_fu.sv
// Pipelined RV32M multiply unit: fixed-latency non-stalling pipeline feeding a result FIFO,
// with credit-based fu_ready so the FIFO can never overflow.
module mul_fu
  import mul_fu_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int FIFO_DEPTH = NUM_STAGES + 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  reservation_station_entry_t issued_entry,
  input  logic [31:0]                rs1_v,
  input  logic [31:0]                rs2_v,
  output logic                       fu_ready,
  input  logic                       branch_flush,
  output logic                       cdb_req,
  input  logic                       cdb_grant,
  output cdb_t                       cdb_out
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = $clog2(NUM_STAGES + FIFO_DEPTH + 4);
  localparam int FIFO_W = PREG_W + ROB_W + 32;

  logic                  r_fu_ready;
  logic                  r_fu_ready_q;
  logic [NUM_STAGES-1:0] r_valid;
  logic [PREG_W-1:0]     r_pd  [NUM_STAGES];
  logic [ROB_W-1:0]      r_rob [NUM_STAGES];
  logic [2:0]            r_f3_s1;
  logic signed [49:0]    r_pp_lo;
  logic signed [47:0]    r_pp_hi;

  logic                  w_accept;
  logic                  w_a_sign;
  logic                  w_b_sign;
  logic signed [32:0]    w_a;
  logic signed [32:0]    w_b;
  logic signed [16:0]    w_b_lo;
  logic signed [16:0]    w_b_hi;
  logic signed [49:0]    w_pp_lo;
  logic signed [47:0]    w_pp_hi;
  logic [63:0]           w_prod;
  logic [31:0]           w_res_s1;
  logic [31:0]           w_res_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [FIFO_W-1:0]     w_head;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_ready_nxt;

  // A held entry was already taken in the cycle after fu_ready was seen high.
  assign w_accept = issued_entry.valid && r_fu_ready_q && !branch_flush;

  // 33x33 signed product split into two 33x17 partial products registered in stage 1.
  always_comb begin
    w_a_sign = (issued_entry.funct3 == MULH) || (issued_entry.funct3 == MULHSU);
    w_b_sign = (issued_entry.funct3 == MULH);
    w_a      = {w_a_sign & rs1_v[31], rs1_v};
    w_b      = {w_b_sign & rs2_v[31], rs2_v};
    w_b_lo   = {1'b0, w_b[15:0]};
    w_b_hi   = w_b[32:16];
    w_pp_lo  = w_a * w_b_lo;
    w_pp_hi  = w_a * w_b_hi;
  end

  assign w_prod   = {r_pp_hi, 16'b0} + {{14{r_pp_lo[49]}}, r_pp_lo};
  assign w_res_s1 = mul_select(r_f3_s1, w_prod);

  generate
    if (NUM_STAGES == 1) begin : g_no_dly
      assign w_res_last = w_res_s1;
    end else begin : g_dly
      logic [31:0] r_res [1:NUM_STAGES-1];
      always_ff @(posedge clk) begin
        r_res[1] <= w_res_s1;
        for (int k = 2; k < NUM_STAGES; k++) r_res[k] <= r_res[k-1];
      end
      assign w_res_last = r_res[NUM_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || branch_flush) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= w_accept;
      for (int k = 1; k < NUM_STAGES; k++) r_valid[k] <= r_valid[k-1];
    end
  end

  always_ff @(posedge clk) begin
    r_f3_s1  <= issued_entry.funct3;
    r_pp_lo  <= w_pp_lo;
    r_pp_hi  <= w_pp_hi;
    r_pd[0]  <= issued_entry.pd;
    r_rob[0] <= issued_entry.rob_index;
    for (int k = 1; k < NUM_STAGES; k++) begin
      r_pd[k]  <= r_pd[k-1];
      r_rob[k] <= r_rob[k-1];
    end
  end

  assign w_pop  = !w_empty && cdb_grant;
  assign w_push = r_valid[NUM_STAGES-1] && (!w_full || w_pop);

  mul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (branch_flush),
    .i_push  (w_push),
    .i_data  ({r_pd[NUM_STAGES-1], r_rob[NUM_STAGES-1], w_res_last}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Two free slots required: one more entry may already be on its way from the station.
  always_comb begin
    w_occ = OCC_W'(w_count) + OCC_W'(w_accept) - OCC_W'(w_pop);
    for (int k = 0; k < NUM_STAGES; k++) w_occ = w_occ + OCC_W'(r_valid[k]);
    w_ready_nxt = (w_occ + OCC_W'(2)) <= OCC_W'(FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fu_ready   <= 1'b1;
      r_fu_ready_q <= 1'b1;
    end else begin
      r_fu_ready_q <= r_fu_ready;
      r_fu_ready   <= branch_flush | w_ready_nxt;
    end
  end

  assign fu_ready = r_fu_ready;
  assign cdb_req  = !w_empty;

  always_comb begin
    cdb_out = '0;
    if (!w_empty) begin
      cdb_out.cdb_valid  = 1'b1;
      cdb_out.preg_index = w_head[FIFO_W-1 -: PREG_W];
      cdb_out.rob_index  = w_head[32 +: ROB_W];
      cdb_out.data       = w_head[31:0];
    end
  end

endmodule
